button_debouncer: RTL and testbench
===================================

// Module: button_debouncer
// PURPOSE
//  Front-end stage directly upstream of up_counter: takes a raw, asynchronous, bouncing push-button,
//  synchronises and debounces it, and emits clean single-cycle press/release pulses.
//  o_press_pulse drives the counter's increment/reset input; o_btn_level gives the stable button state.
// PARAMETERS
//  SYNC_STAGES        2    synchroniser flop count; legal range >= 2
//  DEBOUNCE_CYCLES    16   consecutive stable samples needed to accept a level change; legal range >= 2
//  LONG_PRESS_CYCLES  64   cycles held in PRESSED before o_long_press fires; >= 2, used only with the macro
//  CNT_W              derived, $clog2(max(DEBOUNCE_CYCLES, LONG_PRESS_CYCLES)); localparam, not overridable
// PORTS
//  i_clk            in   1  single clock, rising edge
//  i_reset_n        in   1  asynchronous, active-low reset
//  i_btn            in   1  raw button, active-high, asynchronous to i_clk, may bounce
//  o_btn_level      out  1  debounced stable level (1 = pressed)
//  o_press_pulse    out  1  one-cycle pulse on an accepted 0->1 change
//  o_release_pulse  out  1  one-cycle pulse on an accepted 1->0 change
//  o_long_press     out  1  one-cycle pulse once per press held >= LONG_PRESS_CYCLES (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (i_reset_n=0, asynchronous): synchroniser flops, state, counters and all outputs = 0; state = IDLE.
//  - Synchroniser: i_btn passes through SYNC_STAGES flops; output s. No logic reads i_btn directly.
//  - Outputs are all registered; no combinational path from i_btn to any output.
//  - FSM states: IDLE (stable 0), PRESS_WAIT, PRESSED (stable 1), RELEASE_WAIT.
//    IDLE:         s=1 -> PRESS_WAIT, cnt<=0.
//    PRESS_WAIT:   s=0 -> IDLE, cnt<=0, no pulse (bounce rejected);
//                  s=1 and cnt==DEBOUNCE_CYCLES-1 -> PRESSED, o_press_pulse<=1, o_btn_level<=1;
//                  s=1 otherwise -> cnt<=cnt+1.
//    PRESSED:      s=0 -> RELEASE_WAIT, cnt<=0.
//    RELEASE_WAIT: mirror of PRESS_WAIT. s=1 returns to PRESSED, no pulse;
//                  acceptance -> IDLE, o_release_pulse<=1, o_btn_level<=0.
//  - Latency: the first pin change sampled at edge E reaches s at edge E+SYNC_STAGES-1.
//    The pulse is registered at edge E+SYNC_STAGES+DEBOUNCE_CYCLES, i.e. SYNC_STAGES+DEBOUNCE_CYCLES edges after first sampling.
//  - Pulses are exactly one cycle wide. o_press_pulse and o_release_pulse are never high together.
//  - cnt never exceeds DEBOUNCE_CYCLES-1 in a WAIT state; no wrap.
//  - Reset asserted mid-WAIT or while PRESSED: outputs drop to 0 immediately. No release pulse is produced.
//  - After reset, a button already held high is accepted as a new press after the full latency.
// CONFIGURATION
//  Macro BUTTON_DEBOUNCER_LONG_PRESS_EN:
//   defined  -> a hold counter clears on entry to PRESSED and increments each cycle in PRESSED (RELEASE_WAIT freezes it).
//               On reaching LONG_PRESS_CYCLES-1, o_long_press pulses once; the counter saturates, with no further pulses until next press.
//               The hold counter resets to 0 on i_reset_n.
//   undefined -> the hold counter is not built, o_long_press is tied to 0, and LONG_PRESS_CYCLES is ignored; the port list is unchanged.
// STRUCTURE
//  - Shared package debounce_pkg: FSM state enum (IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT; 2-bit encoding).
//    It also holds the default-parameter constants reused by the up_counter system top.
//  - Sub-module sync_ff (parameter STAGES, async active-low reset to 0) holds the synchroniser chain.
//    It is reusable for other async inputs.
//  - Top-level: FSM, debounce counter, output registers, and the optional hold counter.
// TESTING (bench parameters SYNC_STAGES=2, DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=8, 10-unit clock)
//  1 Reset: hold i_reset_n=0 with i_btn=1 -> all outputs 0. Release reset -> o_press_pulse is high for 1 cycle, 6 edges later.
//  2 Clean press: i_btn 0->1, held -> o_press_pulse 1 cycle at edge 6; o_btn_level=1 from then.
//    Release -> o_release_pulse 1 cycle at edge 6 after the fall.
//  3 Bounce: i_btn toggles 1,0,1,0 every cycle for 6 cycles, then settles 1 -> exactly one o_press_pulse, 6 edges after settling.
//    No o_release_pulse is produced.
//  4 Glitch: 2-cycle high pulse on i_btn while IDLE -> no output change.
//    Same 2-cycle low glitch while PRESSED -> o_btn_level stays 1, no pulses.
//  5 Mid-op reset: assert i_reset_n=0 during PRESS_WAIT and again while PRESSED -> outputs 0 asynchronously, no pulse.
//    Normal presses work after release.
//  6 Macro defined: hold 20 cycles -> one o_long_press, 8 cycles after o_press_pulse, and none afterwards.
//    Macro undefined: o_long_press is constantly 0.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared definitions for the button debouncer: FSM state encoding, default
// parameter values reused by the up_counter system top, and a small helper.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } db_state_t;

  localparam int DEFAULT_SYNC_STAGES       = 2;
  localparam int DEFAULT_DEBOUNCE_CYCLES   = 16;
  localparam int DEFAULT_LONG_PRESS_CYCLES = 64;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for an asynchronous single-bit input; resets to 0.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) chain <= '0;
    else            chain <= {chain[STAGES-2:0], i_d};
  end

  assign o_q = chain[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Synchronises and debounces a raw push-button into clean press/release pulses.
// Optional long-press detection is built when BUTTON_DEBOUNCER_LONG_PRESS_EN is defined.
//
// state        | meaning
// IDLE         | button stable released
// PRESS_WAIT   | counting consecutive pressed samples
// PRESSED      | button stable pressed
// RELEASE_WAIT | counting consecutive released samples
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES       = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_btn,
  output logic o_btn_level,
  output logic o_press_pulse,
  output logic o_release_pulse,
  output logic o_long_press
);

  localparam int CNT_W = $clog2(max_int(DEBOUNCE_CYCLES, LONG_PRESS_CYCLES));
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  db_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic             s;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_d       (i_btn),
    .o_q       (s)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state           <= IDLE;
      cnt             <= '0;
      o_btn_level     <= 1'b0;
      o_press_pulse   <= 1'b0;
      o_release_pulse <= 1'b0;
    end else begin
      o_press_pulse   <= 1'b0;
      o_release_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (s) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state         <= PRESSED;
            cnt           <= '0;
            o_press_pulse <= 1'b1;
            o_btn_level   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!s) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (s) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state           <= IDLE;
            cnt             <= '0;
            o_release_pulse <= 1'b1;
            o_btn_level     <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);

  logic [CNT_W-1:0] hold_cnt;
  logic             hold_done;
  logic             long_press_q;

  // Cleared only on a fresh press; a rejected release bounce resumes the same hold.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      hold_cnt     <= '0;
      hold_done    <= 1'b0;
      long_press_q <= 1'b0;
    end else begin
      long_press_q <= 1'b0;
      if (state == PRESS_WAIT && s && cnt == CNT_LAST) begin
        hold_cnt  <= '0;
        hold_done <= 1'b0;
      end else if (state == PRESSED && s) begin
        if (hold_cnt != HOLD_LAST) begin
          hold_cnt <= hold_cnt + 1'b1;
        end else if (!hold_done) begin
          long_press_q <= 1'b1;
          hold_done    <= 1'b1;
        end
      end
    end
  end

  assign o_long_press = long_press_q;
`else
  assign o_long_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboarded bench for button_debouncer: a run-length reference model predicts
// each cycle's outputs; a monitor compares them one cycle later.
module tb_button_debouncer;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int LPC  = 8;
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
  localparam bit LP_EN = 1'b1;
`else
  localparam bit LP_EN = 1'b0;
`endif

  logic clk, rst_n, btn;
  logic lvl, press, rel, lp;

  button_debouncer #(
    .SYNC_STAGES       (SYNC),
    .DEBOUNCE_CYCLES   (DEB),
    .LONG_PRESS_CYCLES (LPC)
  ) dut (
    .i_clk           (clk),
    .i_reset_n       (rst_n),
    .i_btn           (btn),
    .o_btn_level     (lvl),
    .o_press_pulse   (press),
    .o_release_pulse (rel),
    .o_long_press    (lp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit done = 1'b0;

  logic [3:0] exp_q[$];

  // Reference model: pin samples reach the decision logic SYNC edges late; a level
  // change is accepted after DEB+1 consecutive samples that disagree with the level.
  int m_dly[$];
  bit m_level;
  int m_run;
  int m_hold;
  bit m_fired;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s at %0t: got lvl/press/rel/long=%b expected %b", name, $time, act, req);
    end
  endtask

  task automatic model_reset();
    m_dly.delete();
    for (int i = 0; i < SYNC; i++) m_dly.push_back(0);
    m_level = 1'b0;
    m_run   = 0;
    m_hold  = 0;
    m_fired = 1'b0;
  endtask

  function automatic logic [3:0] model_edge(input bit b);
    bit obs, p, r, l;
    obs = bit'(m_dly.pop_front());
    m_dly.push_back(int'(b));
    p = 0; r = 0; l = 0;
    if (obs != m_level) begin
      m_run++;
      if (m_run == DEB + 1) begin
        m_level = obs;
        m_run   = 0;
        if (obs) begin p = 1; m_hold = 0; m_fired = 0; end
        else     r = 1;
      end
    end else begin
      if (LP_EN && m_level && m_run == 0) begin
        if (m_hold != LPC - 1) m_hold++;
        else if (!m_fired) begin l = 1; m_fired = 1; end
      end
      m_run = 0;
    end
    return {m_level, p, r, l};
  endfunction

  task automatic step(input bit b);
    @(negedge clk);
    btn = b;
    exp_q.push_back(model_edge(b));
  endtask

  task automatic hold(input bit b, input int n);
    for (int i = 0; i < n; i++) step(b);
  endtask

  task automatic do_reset(input bit b_during);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    btn   = b_during;
    #1;
    check("async_reset", {lvl, press, rel, lp}, 4'b0000);
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    check("held_reset", {lvl, press, rel, lp}, 4'b0000);
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    logic [3:0] e;
    while (!done) begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("outputs", {lvl, press, rel, lp}, e);
      end
    end
  end

  initial begin : stim
    rst_n = 1'b0;
    btn   = 1'b1;
    model_reset();
    #12;
    check("power_on_reset", {lvl, press, rel, lp}, 4'b0000);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Button held through reset, then released.
    hold(1, 12);
    hold(0, 12);
    // Clean press and release.
    hold(1, 10);
    hold(0, 10);
    // Bounce settling high, then low.
    for (int i = 0; i < 6; i++) step(bit'(i % 2 == 0));
    hold(1, 10);
    hold(0, 10);
    // Glitches while idle and while pressed.
    hold(1, 2);
    hold(0, 10);
    hold(1, 12);
    hold(0, 2);
    hold(1, 10);
    hold(0, 12);
    // Reset during PRESS_WAIT, then during PRESSED.
    hold(1, 3);
    do_reset(1'b1);
    hold(0, 8);
    hold(1, 12);
    do_reset(1'b0);
    hold(0, 8);
    hold(1, 10);
    hold(0, 10);
    // Long hold.
    hold(1, 22);
    hold(0, 12);
    // Release bounce during a long hold should not re-arm the long press.
    hold(1, 8);
    hold(0, 2);
    hold(1, 14);
    hold(0, 10);
    // Random segments, biased toward lengths around the debounce window.
    for (int seg = 0; seg < 60; seg++) begin
      bit v;
      int n;
      v = bit'($urandom_range(0, 1));
      n = (($urandom & 3) == 0) ? int'($urandom_range(8, 16)) : int'($urandom_range(1, 6));
      hold(v, n);
    end
    hold(0, 10);

    @(posedge clk);
    #2;
    done = 1'b1;
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
